// File: rtl/mul_wb_pkg.sv
// Shared types and constants for the multiplier writeback buffer.
// Optional high-word select is controlled by the MUL_WB_HI_EN macro in the top.
package mul_wb_pkg;

    localparam int MUL_WB_DEPTH = 2;
    localparam int MUL_WB_TAG_W = 5;

    typedef struct packed {
        logic [63:0]             product;
        logic                    sel_hi;
        logic [MUL_WB_TAG_W-1:0] rd;
    } mul_wb_entry_t;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } mul_wb_occ_e;

endpackage

// File: rtl/mul_wb_ovf_detect.sv
// Flags a 64-bit two's-complement product that cannot be represented in signed 32 bits.
module mul_wb_ovf_detect (
    input  logic [63:0] product_i,
    output logic        ovf_o
);

    // Representable iff the upper word is a pure sign extension of bit 31.
    assign ovf_o = (product_i[63:32] != {32{product_i[31]}});

endmodule

// File: rtl/mul_writeback_buffer.sv
// Two-entry result buffer between the Booth multiplier and register-file writeback.
// Define MUL_WB_HI_EN to store and honour in_sel_hi; otherwise the low word is always returned.
module mul_writeback_buffer
    import mul_wb_pkg::*;
#(
    parameter int TAG_W = MUL_WB_TAG_W,
    parameter int DEPTH = MUL_WB_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_product,
    input  logic             in_sel_hi,
    input  logic [TAG_W-1:0] in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_rd,
    output logic             out_ovf,
    output logic [1:0]       count
);

    mul_wb_occ_e      state_q, state_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;

    logic [63:0]      prod_q [MUL_WB_DEPTH];
    logic [TAG_W-1:0] rd_q   [MUL_WB_DEPTH];
`ifdef MUL_WB_HI_EN
    logic             sel_q  [MUL_WB_DEPTH];
`endif

    logic             push_hs;
    logic             push_st;
    logic             pop;
    mul_wb_entry_t    head_e;
    logic             head_ovf;

    assign count     = state_q;
    assign in_ready  = (int'(count) < DEPTH);
    assign out_valid = (state_q != EMPTY);

    // x0 writes complete the handshake but never occupy a slot.
    assign push_hs = in_valid && in_ready;
    assign push_st = push_hs && (in_rd != '0);
    assign pop     = out_valid && out_ready;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_st) wr_ptr_d = ~wr_ptr_q;
        if (pop)     rd_ptr_d = ~rd_ptr_q;
        unique case (state_q)
            EMPTY: if (push_st) state_d = ONE;
            ONE: begin
                if (push_st && !pop)      state_d = FULL;
                else if (!push_st && pop) state_d = EMPTY;
            end
            FULL:    if (pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= EMPTY;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Payload storage carries no reset; validity lives entirely in state_q.
    always_ff @(posedge clk) begin
        if (push_st) begin
            prod_q[wr_ptr_q] <= in_product;
            rd_q[wr_ptr_q]   <= in_rd;
`ifdef MUL_WB_HI_EN
            sel_q[wr_ptr_q]  <= in_sel_hi;
`endif
        end
    end

    always_comb begin
        head_e.product = prod_q[rd_ptr_q];
        head_e.rd      = rd_q[rd_ptr_q];
`ifdef MUL_WB_HI_EN
        head_e.sel_hi  = sel_q[rd_ptr_q];
`else
        head_e.sel_hi  = 1'b0;
`endif
    end

    mul_wb_ovf_detect u_ovf (
        .product_i (head_e.product),
        .ovf_o     (head_ovf)
    );

`ifdef MUL_WB_HI_EN
    logic [31:0] head_word;
    assign head_word = head_e.sel_hi ? head_e.product[63:32] : head_e.product[31:0];
`else
    logic [31:0] head_word;
    logic        unused_sel;
    assign head_word  = head_e.product[31:0];
    assign unused_sel = in_sel_hi ^ head_e.sel_hi;
`endif

    assign out_data = out_valid ? head_word : 32'd0;
    assign out_rd   = out_valid ? head_e.rd : '0;
    assign out_ovf  = out_valid & head_ovf;

endmodule

// File: tb/tb_mul_writeback_buffer.sv
// Directed self-checking bench for mul_writeback_buffer.
module tb_mul_writeback_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_product;
    logic        in_sel_hi;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        out_ovf;
    logic [1:0]  count;

    int n_checks = 0;
    int n_pass   = 0;

    mul_writeback_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_product (in_product),
        .in_sel_hi  (in_sel_hi),
        .in_rd      (in_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_rd     (out_rd),
        .out_ovf    (out_ovf),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] p, input logic s, input logic [4:0] r);
        in_valid   = v;
        in_product = p;
        in_sel_hi  = s;
        in_rd      = r;
    endtask

    logic [31:0] exp_hi_word;

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 64'd0, 1'b0, 5'd0);
`ifdef MUL_WB_HI_EN
        exp_hi_word = 32'h1;
`else
        exp_hi_word = 32'h0;
`endif
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_rd", out_rd, 0);
        chk("rst_out_ovf", out_ovf, 0);
        chk("rst_count", count, 0);
        rst = 1'b0;
        tick();

        // Simple low-word push
        drive(1'b1, 64'h0000_0000_0000_0006, 1'b0, 5'd3);
        tick();
        drive(1'b0, 64'd0, 1'b0, 5'd0);
        chk("p1_valid", out_valid, 1);
        chk("p1_data", out_data, 32'h6);
        chk("p1_rd", out_rd, 3);
        chk("p1_ovf", out_ovf, 0);
        chk("p1_count", count, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("p1_pop_count", count, 0);
        chk("p1_pop_valid", out_valid, 0);

        // High-word select and overflow
        drive(1'b1, 64'h0000_0001_0000_0000, 1'b1, 5'd7);
        tick();
        drive(1'b0, 64'd0, 1'b0, 5'd0);
        chk("hi_data", out_data, exp_hi_word);
        chk("hi_rd", out_rd, 7);
        chk("hi_ovf", out_ovf, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Fill under backpressure, reject third, drain in order
        drive(1'b1, 64'h11, 1'b0, 5'd1);
        tick();
        drive(1'b1, 64'h22, 1'b0, 5'd2);
        tick();
        chk("full_count", count, 2);
        chk("full_in_ready", in_ready, 0);
        drive(1'b1, 64'h33, 1'b0, 5'd4);
        tick();
        chk("full_hold_count", count, 2);
        chk("full_hold_data", out_data, 32'h11);
        chk("full_hold_rd", out_rd, 1);
        drive(1'b0, 64'd0, 1'b0, 5'd0);
        out_ready = 1'b1;
        tick();
        chk("drain1_data", out_data, 32'h22);
        chk("drain1_rd", out_rd, 2);
        chk("drain1_count", count, 1);
        tick();
        chk("drain2_count", count, 0);
        chk("drain2_valid", out_valid, 0);
        chk("drain2_data", out_data, 0);
        out_ready = 1'b0;

        // x0 destination is accepted and dropped
        drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 5'd0);
        #1;
        chk("x0_in_ready", in_ready, 1);
        tick();
        drive(1'b0, 64'd0, 1'b0, 5'd0);
        chk("x0_count", count, 0);
        chk("x0_valid", out_valid, 0);

        // Negative in-range product: no overflow
        drive(1'b1, 64'hFFFF_FFFF_8000_0000, 1'b0, 5'd5);
        tick();
        drive(1'b0, 64'd0, 1'b0, 5'd0);
        chk("neg_data", out_data, 32'h8000_0000);
        chk("neg_ovf", out_ovf, 0);

        // Simultaneous push/pop at ONE, across pointer wrap
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, {32'h0000_0000, 32'h200 + 32'(i)}, 1'b0, 5'(8 + i));
            out_ready = 1'b1;
            tick();
            chk("pp_count", count, 1);
            chk("pp_data", out_data, 32'h200 + 32'(i));
            chk("pp_rd", out_rd, 8 + i);
        end
        // Positive value just past 32-bit range
        drive(1'b1, 64'h0000_0000_8000_0000, 1'b0, 5'd12);
        tick();
        drive(1'b0, 64'd0, 1'b0, 5'd0);
        chk("pos_ovf", out_ovf, 1);
        chk("pos_rd", out_rd, 12);
        tick();
        out_ready = 1'b0;
        chk("pp_drained", count, 0);

        // Asynchronous reset while full
        drive(1'b1, 64'h44, 1'b0, 5'd9);
        tick();
        drive(1'b1, 64'h55, 1'b0, 5'd10);
        tick();
        drive(1'b0, 64'd0, 1'b0, 5'd0);
        chk("pre_rst_count", count, 2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", count, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_valid", out_valid, 0);
        chk("arst_data", out_data, 0);
        chk("arst_rd", out_rd, 0);
        chk("arst_ovf", out_ovf, 0);
        #10;
        rst = 1'b0;
        tick();
        chk("post_rst_count", count, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
